mult_hazard_controller: RTL and testbench
=========================================

Name: mult_hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V core with a multi-cycle multiplier in EX.
- Detects load-use hazards and inserts a bubble.
- Sequences the MULT_LATENCY-cycle multiplier by freezing the front end and padding EX/MEM with bubbles.
- Generates taken-branch flushes.
- Sits beside the forwarding unit. It drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- MULT_LATENCY, 3, EX-stage cycles a mult instruction occupies (legal 1..16).
- CNT_W, $clog2(MULT_LATENCY)+1, width of the internal latency counter.

Ports:
- clk  input  1  system clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- rs1_if_id  input  5  rs1 field of the instruction in ID.
- rs2_if_id  input  5  rs2 field of the instruction in ID.
- rd_id_ex  input  5  destination register of the instruction in EX.
- mem_read_id_ex  input  1  instruction in EX is a load.
- mult_id_ex  input  1  instruction in EX is a mult.
- branch_taken_ex  input  1  branch or jump resolved taken in EX.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID register enable.
- id_ex_write  output  1  ID/EX register enable (0 = hold).
- if_id_flush  output  1  load NOP into IF/ID.
- id_ex_flush  output  1  load NOP (all control zero) into ID/EX.
- ex_mem_bubble  output  1  load NOP into EX/MEM (RegWrite=0, MemWrite=0).
- mult_start  output  1  one-cycle pulse that launches the multiplier.
- mult_done  output  1  multiplier result is valid this cycle; EX/MEM captures it.
- busy  output  1  FSM is in RUN.

Behaviour:
- Reset (arst_n low, asynchronous):
  - state=IDLE, cnt=0.
  - All outputs take inactive values: pc_write=1, if_id_write=1, id_ex_write=1, all flush and bubble outputs 0, mult_start=0, mult_done=0, busy=0.
- Outputs are combinational from state, cnt and the inputs. Only state and cnt are registered.
- FSM states: IDLE, RUN.
- IDLE with mult_id_ex=1:
  - mult_start=1.
  - If MULT_LATENCY==1: mult_done=1, no stall, stay IDLE.
  - Else: stall cycle; next state RUN, cnt<=MULT_LATENCY-2.
- RUN:
  - busy=1, mult_start=0.
  - If cnt!=0: stall cycle; cnt<=cnt-1.
  - If cnt==0: mult_done=1, no stall, next state IDLE. The mult instruction advances into EX/MEM this cycle.
- Mult stall cycle: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
  - A mult therefore costs exactly MULT_LATENCY-1 stall cycles. For MULT_LATENCY=3 the stall covers T0 and T1; mult_done is asserted at T2.
- Back-to-back mults: the second mult enters EX on the cycle after mult_done.
  - It starts in IDLE and receives its own mult_start.
  - The FSM never restarts while in RUN.
- Load-use hazard: condition is mem_read_id_ex && rd_id_ex!=0 && (rd_id_ex==rs1_if_id || rd_id_ex==rs2_if_id).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle.
- Branch taken: if_id_flush=1, id_ex_flush=1, pc_write=1.
- Priority: mult stall > branch flush > load-use.
  - All three are mutually exclusive in legal code because EX holds only one instruction type.
  - The priority still applies if the inputs overlap. During a mult stall, id_ex_flush and if_id_flush are forced to 0.
- rd_id_ex==0 never creates a load-use stall.
- Reset asserted mid-RUN: the FSM returns to IDLE immediately and no mult_done is issued.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Extra output ports stall_cycles (32-bit) and mult_count (16-bit).
  - stall_cycles increments on every cycle with pc_write==0.
  - mult_count increments on every mult_start.
  - Both counters saturate at all-ones and are cleared by arst_n.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with all inputs 0 -> pc_write=1, if_id_write=1, id_ex_write=1, all flush/bubble/mult outputs 0, busy=0.
- Load rd=5 in EX, rs1_if_id=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Same stimulus with rd=0 -> no stall.
- mult_id_ex=1 for 3 cycles with MULT_LATENCY=3:
  - cycle 0: mult_start=1, stall, ex_mem_bubble=1.
  - cycle 1: stall, busy=1.
  - cycle 2: mult_done=1, pc_write=1, then IDLE.
- Two consecutive mults -> two mult_start pulses 3 cycles apart, 4 total stall cycles, two mult_done pulses.
- branch_taken_ex=1 -> if_id_flush=1 and id_ex_flush=1 for that cycle, pc_write=1.
- Assert arst_n=0 in RUN cycle 1 -> outputs immediately go inactive, busy=0. After release, mult_id_ex=1 produces a fresh mult_start. MULT_LATENCY=1 build: a mult gives mult_start=mult_done=1 in the same cycle with no stall.

Source files
------------

// File: rtl/mult_hazard_controller_if.sv
// mult_hazard_controller_if: ID/EX hazard inputs and pipeline control outputs; HAZARD_STALL_CNT_EN adds counters
interface mult_hazard_controller_if;
    logic [4:0]  rs1_if_id;
    logic [4:0]  rs2_if_id;
    logic [4:0]  rd_id_ex;
    logic        mem_read_id_ex;
    logic        mult_id_ex;
    logic        branch_taken_ex;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        mult_start;
    logic        mult_done;
    logic        busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] mult_count;
`endif
    modport master (
        output rs1_if_id, rs2_if_id, rd_id_ex, mem_read_id_ex, mult_id_ex, branch_taken_ex,
        input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_bubble, mult_start, mult_done, busy
`ifdef HAZARD_STALL_CNT_EN
        , input stall_cycles, mult_count
`endif
    );
    modport slave (
        input  rs1_if_id, rs2_if_id, rd_id_ex, mem_read_id_ex, mult_id_ex, branch_taken_ex,
        output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
               ex_mem_bubble, mult_start, mult_done, busy
`ifdef HAZARD_STALL_CNT_EN
        , output stall_cycles, mult_count
`endif
    );
endinterface

// File: rtl/mult_hazard_controller.sv
// mult_hazard_controller: load-use/branch/multi-cycle-mult pipeline control; HAZARD_STALL_CNT_EN adds stall/mult counters
module mult_hazard_controller #(
    parameter int MULT_LATENCY = 3,
    parameter int CNT_W        = $clog2(MULT_LATENCY) + 1
) (
    input logic                     clk,
    input logic                     arst_n,
    mult_hazard_controller_if.slave hz
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LATENCY > 1 ? MULT_LATENCY - 2 : 0);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_run, cnt_zero, start, run_start, stall, done, load_use, branch;
    always_comb begin
        in_run    = state_q == RUN;
        cnt_zero  = cnt_q == '0;
        start     = arst_n && !in_run && hz.mult_id_ex;
        run_start = start && MULT_LATENCY > 1;
        stall     = run_start || (arst_n && in_run && !cnt_zero);
        done      = (start && MULT_LATENCY == 1) || (arst_n && in_run && cnt_zero);
        branch    = arst_n && !stall && hz.branch_taken_ex;
        load_use  = arst_n && !stall && !branch && hz.mem_read_id_ex && hz.rd_id_ex != 5'd0 &&
                    (hz.rd_id_ex == hz.rs1_if_id || hz.rd_id_ex == hz.rs2_if_id);
        state_d   = run_start ? RUN : (in_run && cnt_zero) ? IDLE : state_q;
        cnt_d     = run_start ? CNT_INIT : (in_run && !cnt_zero) ? cnt_q - CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign hz.pc_write      = !(stall || load_use);
    assign hz.if_id_write   = !(stall || load_use);
    assign hz.id_ex_write   = !stall;
    assign hz.if_id_flush   = branch;
    assign hz.id_ex_flush   = branch || load_use;
    assign hz.ex_mem_bubble = stall;
    assign hz.mult_start    = start;
    assign hz.mult_done     = done;
    assign hz.busy          = arst_n && in_run;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] mult_count_q;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles_q <= '0;
            mult_count_q   <= '0;
        end else begin
            if (!hz.pc_write && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (start && mult_count_q != '1) mult_count_q <= mult_count_q + 16'd1;
        end
    end
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.mult_count   = mult_count_q;
`endif
endmodule

// File: tb/tb_mult_hazard_controller.sv
// tb_mult_hazard_controller: table-driven check of a MULT_LATENCY=3 and a MULT_LATENCY=1 controller
module tb_mult_hazard_controller;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    mult_hazard_controller_if h3 ();
    mult_hazard_controller_if h1 ();
    mult_hazard_controller #(.MULT_LATENCY(3)) dut3 (.clk(clk), .arst_n(arst_n), .hz(h3.slave));
    mult_hazard_controller #(.MULT_LATENCY(1)) dut1 (.clk(clk), .arst_n(arst_n), .hz(h1.slave));
    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, mult_start, mult_done, busy}
    localparam logic [8:0] DEF = 9'b111_00_000_0;
    localparam logic [8:0] LU  = 9'b001_01_000_0;
    localparam logic [8:0] BR  = 9'b111_11_000_0;
    localparam logic [8:0] M0  = 9'b000_00_110_0;
    localparam logic [8:0] M1  = 9'b000_00_100_1;
    localparam logic [8:0] MD  = 9'b111_00_001_1;
    localparam logic [8:0] S1  = 9'b111_00_011_0;
    localparam logic [8:0] S1B = 9'b111_11_011_0;
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       mr, mult, br;
        logic [8:0] exp3, exp1;
    } vec_t;
    logic [8:0] o3, o1;
    assign o3 = {h3.pc_write, h3.if_id_write, h3.id_ex_write, h3.if_id_flush, h3.id_ex_flush,
                 h3.ex_mem_bubble, h3.mult_start, h3.mult_done, h3.busy};
    assign o1 = {h1.pc_write, h1.if_id_write, h1.id_ex_write, h1.if_id_flush, h1.id_ex_flush,
                 h1.ex_mem_bubble, h1.mult_start, h1.mult_done, h1.busy};
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        h3.rs1_if_id = v.rs1; h3.rs2_if_id = v.rs2; h3.rd_id_ex = v.rd;
        h3.mem_read_id_ex = v.mr; h3.mult_id_ex = v.mult; h3.branch_taken_ex = v.br;
        h1.rs1_if_id = v.rs1; h1.rs2_if_id = v.rs2; h1.rd_id_ex = v.rd;
        h1.mem_read_id_ex = v.mr; h1.mult_id_ex = v.mult; h1.branch_taken_ex = v.br;
    endtask
    vec_t tab[17];
    vec_t z;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_base;
    logic [15:0] mult_base;
`endif
    initial begin
        z = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, mr: 1'b0, mult: 1'b0, br: 1'b0, exp3: DEF, exp1: DEF};
        tab[0]  = z;
        tab[1]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, LU,  LU};
        tab[2]  = '{5'd3,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, LU,  LU};
        tab[3]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, DEF, DEF};
        tab[4]  = '{5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, DEF, DEF};
        tab[5]  = '{5'd6,  5'd7,  5'd5,  1'b1, 1'b0, 1'b0, DEF, DEF};
        tab[6]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, BR,  BR};
        tab[7]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, BR,  BR};
        tab[8]  = '{5'd0,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, LU,  LU};
        tab[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, M0,  S1B};
        tab[10] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, M1,  S1};
        tab[11] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, MD,  S1};
        tab[12] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, M0,  S1};
        tab[13] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b1, M1,  S1B};
        tab[14] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, MD,  S1};
        tab[15] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, LU,  LU};
        tab[16] = z;
        drive(z);
        #1;
        chk("reset_l3", 32'(o3), 32'(DEF));
        chk("reset_l1", 32'(o1), 32'(DEF));
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tab[i]);
            #1;
            chk($sformatf("vec%0d_l3", i), 32'(o3), 32'(tab[i].exp3));
            chk($sformatf("vec%0d_l1", i), 32'(o1), 32'(tab[i].exp1));
`ifdef HAZARD_STALL_CNT_EN
            if (i == 9) begin
                stall_base = h3.stall_cycles;
                mult_base  = h3.mult_count;
            end
            if (i == 15) begin
                chk("stall_cycles_delta", h3.stall_cycles - stall_base, 32'd4);
                chk("mult_count_delta", 32'(h3.mult_count - mult_base), 32'd2);
            end
`endif
        end
        // reset while the multiplier is mid-run, with mult still requested
        z.mult = 1'b1;
        @(negedge clk);
        drive(z);
        #1;
        chk("rst_seq_start", 32'(o3), 32'(M0));
        @(negedge clk);
        #1;
        chk("rst_seq_run", 32'(o3), 32'(M1));
        arst_n = 1'b0;
        #1;
        chk("rst_mid_run", 32'(o3), 32'(DEF));
        chk("rst_mid_run_l1", 32'(o1), 32'(DEF));
        @(negedge clk);
        #1;
        chk("rst_held", 32'(o3), 32'(DEF));
        arst_n = 1'b1;
        #1;
        chk("rst_fresh_start", 32'(o3), 32'(M0));
        @(negedge clk);
        #1;
        chk("rst_fresh_run", 32'(o3), 32'(M1));
        @(negedge clk);
        #1;
        chk("rst_fresh_done", 32'(o3), 32'(MD));
        z.mult = 1'b0;
        @(negedge clk);
        drive(z);
        #1;
        chk("rst_seq_idle", 32'(o3), 32'(DEF));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
